// File: rtl/array_dn_mp.sv
// Multi-read-port register array with segment-masked writes, per-entry valid bits,
// bulk invalidate and optional write-to-read forwarding. Read results are registered.
module array_dn_mp #(
    parameter int unsigned DWTH   = 18,
    parameter int unsigned AWTH   = 3,
    parameter int unsigned DEPTH  = 8,
    parameter int unsigned NRD    = 2,
    parameter int unsigned MWTH   = 2,
    parameter int unsigned BYPASS = 1
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  wen_i,
    input  logic [AWTH-1:0]       waddr_i,
    input  logic [MWTH-1:0]       wmask_i,
    input  logic [DWTH-1:0]       wdata_i,
    input  logic                  flush_i,
    input  logic [NRD-1:0]        ren_i,
    input  logic [NRD*AWTH-1:0]   raddr_i,
    output logic [NRD*DWTH-1:0]   rdata_o,
    output logic [NRD-1:0]        rvld_o
);

    localparam int unsigned SW = DWTH / MWTH;

    logic [DEPTH-1:0][DWTH-1:0] mem_q, mem_d;
    logic [DEPTH-1:0]           vld_q, vld_d;
    logic [NRD-1:0][DWTH-1:0]   rdata_q, rdata_d;
    logic [NRD-1:0]             rvld_q, rvld_d;

    logic            waddr_ok;
    logic            wr_hit;
    logic [DWTH-1:0] wr_old;
    logic [DWTH-1:0] wr_merged;

    // Write path: merge masked segments over the current entry contents.
    always_comb begin
        waddr_ok  = 32'(waddr_i) < DEPTH;
        wr_hit    = wen_i && waddr_ok && (|wmask_i);
        wr_old    = '0;
        if (waddr_ok) begin
            wr_old = mem_q[waddr_i];
        end
        wr_merged = wr_old;
        for (int s = 0; s < MWTH; s++) begin
            if (wmask_i[s]) begin
                wr_merged[s*SW +: SW] = wdata_i[s*SW +: SW];
            end
        end

        mem_d = mem_q;
        vld_d = flush_i ? '0 : vld_q;
        if (wr_hit) begin
            mem_d[waddr_i] = wr_merged;
            vld_d[waddr_i] = 1'b1;
        end
    end

    // Read path: every port sees pre-edge state unless forwarding applies.
    always_comb begin
        logic [AWTH-1:0] rd_addr;
        rd_addr = '0;
        rdata_d = rdata_q;
        rvld_d  = rvld_q;
        for (int k = 0; k < NRD; k++) begin
            rd_addr = raddr_i[k*AWTH +: AWTH];
            if (ren_i[k]) begin
                if (32'(rd_addr) >= DEPTH) begin
                    rdata_d[k] = '0;
                    rvld_d[k]  = 1'b0;
                end else if ((BYPASS != 0) && wr_hit && (waddr_i == rd_addr)) begin
                    rdata_d[k] = wr_merged;
                    rvld_d[k]  = 1'b1;
                end else begin
                    rdata_d[k] = mem_q[rd_addr];
                    rvld_d[k]  = vld_q[rd_addr];
                end
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            mem_q   <= '0;
            vld_q   <= '0;
            rdata_q <= '0;
            rvld_q  <= '0;
        end else begin
            mem_q   <= mem_d;
            vld_q   <= vld_d;
            rdata_q <= rdata_d;
            rvld_q  <= rvld_d;
        end
    end

    assign rdata_o = rdata_q;
    assign rvld_o  = rvld_q;

endmodule

// File: tb/tb_array_dn_mp.sv
// Directed bench for array_dn_mp: default, no-forwarding and DEPTH=6 instances share stimulus.
module tb_array_dn_mp;

    logic        clk;
    logic        rst;
    logic        wen;
    logic [2:0]  waddr;
    logic [1:0]  wmask;
    logic [17:0] wdata;
    logic        flush;
    logic [1:0]  ren;
    logic [5:0]  raddr;

    logic [35:0] rdata_a, rdata_b, rdata_c;
    logic [1:0]  rvld_a, rvld_b, rvld_c;

    int n_checks = 0;
    int n_fail   = 0;

    array_dn_mp u_dut (
        .clk_i(clk), .rst_i(rst), .wen_i(wen), .waddr_i(waddr), .wmask_i(wmask),
        .wdata_i(wdata), .flush_i(flush), .ren_i(ren), .raddr_i(raddr),
        .rdata_o(rdata_a), .rvld_o(rvld_a)
    );

    array_dn_mp #(.BYPASS(0)) u_dut_nb (
        .clk_i(clk), .rst_i(rst), .wen_i(wen), .waddr_i(waddr), .wmask_i(wmask),
        .wdata_i(wdata), .flush_i(flush), .ren_i(ren), .raddr_i(raddr),
        .rdata_o(rdata_b), .rvld_o(rvld_b)
    );

    array_dn_mp #(.DEPTH(6)) u_dut_d6 (
        .clk_i(clk), .rst_i(rst), .wen_i(wen), .waddr_i(waddr), .wmask_i(wmask),
        .wdata_i(wdata), .flush_i(flush), .ren_i(ren), .raddr_i(raddr),
        .rdata_o(rdata_c), .rvld_o(rvld_c)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; inputs are driven and outputs sampled 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_write(input logic [2:0] a, input logic [1:0] m, input logic [17:0] d);
        wen   = 1'b1;
        waddr = a;
        wmask = m;
        wdata = d;
    endtask

    task automatic do_read(input logic [1:0] en, input logic [2:0] a1, input logic [2:0] a0);
        ren   = en;
        raddr = {a1, a0};
    endtask

    task automatic idle();
        wen   = 1'b0;
        wmask = 2'b00;
        flush = 1'b0;
        ren   = 2'b00;
    endtask

    initial begin
        rst = 1'b0;
        wen = 1'b0; waddr = '0; wmask = '0; wdata = '0; flush = 1'b0;
        ren = '0; raddr = '0;
        tick();
        tick();
        check_eq("reset_rdata", 64'(rdata_a), 64'h0);
        check_eq("reset_rvld", 64'(rvld_a), 64'h0);

        // Reset release then read of never-written entries
        rst = 1'b1;
        do_read(2'b11, 3'd3, 3'd0);
        tick();
        check_eq("post_reset_rdata", 64'(rdata_a), 64'h0);
        check_eq("post_reset_rvld", 64'(rvld_a), 64'h0);

        // Full write then read with one-cycle latency
        idle();
        do_write(3'd5, 2'b11, 18'h2A5A5);
        tick();
        idle();
        do_read(2'b01, 3'd0, 3'd5);
        tick();
        check_eq("wr_rd_data", 64'(rdata_a[17:0]), 64'h2A5A5);
        check_eq("wr_rd_vld", 64'(rvld_a[0]), 64'h1);
        idle();
        raddr = {3'd0, 3'd0};
        for (int i = 0; i < 4; i++) begin
            tick();
            check_eq("hold_data", 64'(rdata_a[17:0]), 64'h2A5A5);
        end
        check_eq("hold_vld", 64'(rvld_a[0]), 64'h1);

        // Upper-segment-only write
        do_write(3'd5, 2'b10, 18'h3FFFF);
        tick();
        idle();
        do_read(2'b01, 3'd0, 3'd5);
        tick();
        check_eq("partial_wr", 64'(rdata_a[17:0]), 64'h3FFA5);

        // Forwarding into a valid entry, both ports on the same address
        idle();
        do_write(3'd2, 2'b11, 18'h3FE00);
        tick();
        do_write(3'd2, 2'b01, 18'h00033);
        do_read(2'b11, 3'd2, 3'd2);
        tick();
        check_eq("byp_p0", 64'(rdata_a[17:0]), 64'h3FE33);
        check_eq("byp_p1", 64'(rdata_a[35:18]), 64'h3FE33);
        check_eq("byp_vld", 64'(rvld_a), 64'h3);
        check_eq("nobyp_p0", 64'(rdata_b[17:0]), 64'h3FE00);
        check_eq("nobyp_p1", 64'(rdata_b[35:18]), 64'h3FE00);
        check_eq("nobyp_vld", 64'(rvld_b), 64'h3);

        // Forwarding into an invalid entry; non-forwarding sees old invalid zero
        do_write(3'd3, 2'b01, 18'h00055);
        do_read(2'b11, 3'd3, 3'd3);
        tick();
        check_eq("byp_inv_data", 64'(rdata_a), {28'h0, 18'h00055, 18'h00055});
        check_eq("byp_inv_vld", 64'(rvld_a), 64'h3);
        check_eq("nobyp_inv_data", 64'(rdata_b), 64'h0);
        check_eq("nobyp_inv_vld", 64'(rvld_b), 64'h0);

        // Zero mask: no write, no forwarding
        do_write(3'd6, 2'b00, 18'h3FFFF);
        do_read(2'b01, 3'd0, 3'd6);
        tick();
        check_eq("mask0_byp_data", 64'(rdata_a[17:0]), 64'h0);
        check_eq("mask0_byp_vld", 64'(rvld_a[0]), 64'h0);
        idle();
        do_read(2'b01, 3'd0, 3'd6);
        tick();
        check_eq("mask0_after_vld", 64'(rvld_a[0]), 64'h0);

        // Fill all entries, then flush with a simultaneous write to entry 4
        idle();
        for (int i = 0; i < 8; i++) begin
            do_write(3'(i), 2'b11, 18'h10000 | 18'(i));
            tick();
        end
        do_write(3'd4, 2'b11, 18'h0ABCD);
        flush = 1'b1;
        do_read(2'b11, 3'd4, 3'd0);
        tick();
        check_eq("flush_cyc_p0", 64'(rdata_a[17:0]), 64'h10000);
        check_eq("flush_cyc_p1", 64'(rdata_a[35:18]), 64'h0ABCD);
        check_eq("flush_cyc_vld", 64'(rvld_a), 64'h3);
        idle();
        for (int i = 0; i < 8; i += 2) begin
            logic [17:0] e0, e1;
            logic [1:0]  ev;
            e0 = (i == 4) ? 18'h0ABCD : (18'h10000 | 18'(i));
            e1 = 18'h10000 | 18'(i + 1);
            ev = {1'b0, (i == 4)};
            do_read(2'b11, 3'(i + 1), 3'(i));
            tick();
            check_eq("flush_data", 64'(rdata_a), {28'h0, e1, e0});
            check_eq("flush_vld", 64'(rvld_a), 64'(ev));
        end

        // Out-of-range on the DEPTH=6 instance
        idle();
        do_write(3'd7, 2'b11, 18'h3FFFF);
        tick();
        idle();
        do_read(2'b11, 3'd7, 3'd5);
        tick();
        check_eq("oor_rd_data", 64'(rdata_c[35:18]), 64'h0);
        check_eq("oor_rd_vld", 64'(rvld_c[1]), 64'h0);
        check_eq("oor_keep5", 64'(rdata_c[17:0]), 64'h10005);
        do_read(2'b11, 3'd6, 3'd1);
        tick();
        check_eq("oor_keep1", 64'(rdata_c), {28'h0, 18'h0, 18'h10001});
        check_eq("oor_rd6_vld", 64'(rvld_c), 64'h0);

        // Asynchronous reset mid-cycle
        do_read(2'b11, 3'd4, 3'd4);
        tick();
        idle();
        check_eq("pre_rst_vld", 64'(rvld_a), 64'h3);
        #2;
        rst = 1'b0;
        #1;
        check_eq("async_rst_data", 64'(rdata_a), 64'h0);
        check_eq("async_rst_vld", 64'(rvld_a), 64'h0);
        tick();
        rst = 1'b1;
        do_read(2'b01, 3'd0, 3'd4);
        tick();
        check_eq("rst_cleared_entry", 64'(rdata_a[17:0]), 64'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
